// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment patterns are active-low in bit order g..a ([6:0]).
package seg7_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_SHOW  = 2'b10
  } state_e;

  localparam logic [7:0] LEDS_OFF  = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b0100111;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for one nibble
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered display data,
// per-slot anode dead time and optional leading-zero suppression.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_lz_blank,
  output logic [7:0]              o_leds,
  output logic [NUM_DIGITS-1:0]   o_anode,
  output logic                    o_frame
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE    = CW'(TICK_DIV - 2);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1'b1);
  localparam logic [IW-1:0] IDX_ZERO   = {IW{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cnt_nxt_s;
  logic [IW-1:0]           idx_r;
  logic [IW-1:0]           idx_nxt_s;
  logic                    frame_r;
  logic                    frame_nxt_s;

  logic [4*NUM_DIGITS-1:0] pend_val_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [4*NUM_DIGITS-1:0] shadow_val_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;

  logic [3:0]              nibble_s;
  logic [6:0]              seg_s;
  logic [NUM_DIGITS-1:0]   lz_zero_s;
  logic                    blank_digit_s;
  logic [7:0]              leds_nxt_s;
  logic [NUM_DIGITS-1:0]   anode_nxt_s;
  logic [7:0]              leds_r;
  logic [NUM_DIGITS-1:0]   anode_r;

  // Scan state, slot counter, digit index and frame marker registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      frame_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      frame_r <= frame_nxt_s;
    end
  end

  // Next-state logic for the slot sequencer
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    if (!i_enable) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
      idx_nxt_s   = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = IDX_ZERO;
        end
        ST_BLANK: begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_r == BLANK_LAST) begin
            state_nxt_s = ST_SHOW;
          end else begin
            state_nxt_s = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_BLANK;
            cnt_nxt_s   = CNT_ZERO;
            if (idx_r == IDX_LAST) begin
              idx_nxt_s = IDX_ZERO;
            end else begin
              idx_nxt_s = idx_r + IDX_ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = IDX_ZERO;
        end
      endcase
    end
  end

  // Registered so that o_frame is high during the final SHOW cycle of the last digit
  always_comb begin
    if (i_enable && (state_r != ST_IDLE) && (cnt_r == CNT_PRE) && (idx_r == IDX_LAST)) begin
      frame_nxt_s = 1'b1;
    end else begin
      frame_nxt_s = 1'b0;
    end
  end

  // Pending/shadow double buffer; shadow only changes at a frame boundary or while dark
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
    end else if ((state_r == ST_IDLE) && i_load) begin
      pend_val_r   <= i_value;
      pend_dp_r    <= i_dp;
      shadow_val_r <= i_value;
      shadow_dp_r  <= i_dp;
    end else if (frame_r) begin
      if (i_load) begin
        pend_val_r   <= i_value;
        pend_dp_r    <= i_dp;
        shadow_val_r <= i_value;
        shadow_dp_r  <= i_dp;
      end else begin
        shadow_val_r <= pend_val_r;
        shadow_dp_r  <= pend_dp_r;
      end
    end else if (i_load) begin
      pend_val_r <= i_value;
      pend_dp_r  <= i_dp;
    end
  end

  assign nibble_s = shadow_val_r[{idx_r, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble (nibble_s),
    .seg    (seg_s)
  );

  // lz_zero_s[k]: nibble k and every more significant nibble are zero
  always_comb begin
    lz_zero_s = {NUM_DIGITS{1'b0}};
    lz_zero_s[NUM_DIGITS-1] = (shadow_val_r[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz_zero_s[k] = lz_zero_s[k+1] && (shadow_val_r[4*k +: 4] == 4'h0);
    end
  end

  assign blank_digit_s = i_lz_blank && (idx_r != IDX_ZERO) && lz_zero_s[idx_r];

  // Output pattern for the current slot
  always_comb begin
    leds_nxt_s  = LEDS_OFF;
    anode_nxt_s = ANODE_OFF;
    if (state_r == ST_SHOW) begin
      anode_nxt_s = ~(ONE_HOT0 << idx_r);
      if (blank_digit_s) begin
        leds_nxt_s = {~shadow_dp_r[idx_r], SEG_BLANK};
      end else begin
        leds_nxt_s = {~shadow_dp_r[idx_r], seg_s};
      end
    end else begin
      leds_nxt_s  = LEDS_OFF;
      anode_nxt_s = ANODE_OFF;
    end
  end

  // Glitch-free registered segment and anode drive
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      leds_r  <= LEDS_OFF;
      anode_r <= ANODE_OFF;
    end else begin
      leds_r  <= leds_nxt_s;
      anode_r <= anode_nxt_s;
    end
  end

  assign o_leds  = leds_r;
  assign o_anode = anode_r;
  assign o_frame = frame_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based reference model predicts each
// cycle's outputs into a queue, and a negedge monitor compares them.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * TD;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] leds;
    logic       frame;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz;
  logic [7:0]  o_leds;
  logic [3:0]  o_anode;
  logic        o_frame;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Model state: p_m is cycles since scanning (re)started, -1 while dark
  int          p_m = -1;
  logic [15:0] pend_m = 16'h0;
  logic [15:0] shad_m = 16'h0;
  logic [3:0]  pdp_m = 4'h0;
  logic [3:0]  sdp_m = 4'h0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enable   (en),
    .i_value    (value),
    .i_dp       (dp),
    .i_load     (load),
    .i_lz_blank (lz),
    .o_leds     (o_leds),
    .o_anode    (o_anode),
    .o_frame    (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: predict the outputs visible after this edge
  always @(posedge clk) begin : model
    exp_t e;
    int old_p;
    int dig;
    logic [3:0] nib;
    old_p = p_m;
    e.anode = 4'hF;
    e.leds  = 8'hFF;
    e.frame = 1'b0;
    if (!rst && old_p >= 0 && (old_p % TD) >= BC) begin
      dig = (old_p / TD) % ND;
      nib = shad_m[dig*4 +: 4];
      e.anode = ~(4'b0001 << dig);
      e.leds[7] = ~sdp_m[dig];
      if (lz && dig > 0 && (shad_m >> (4 * dig)) == 16'h0) e.leds[6:0] = 7'b1111111;
      else e.leds[6:0] = SEG_REF[nib];
    end
    if (rst || !en) p_m = -1;
    else if (old_p < 0) p_m = 0;
    else p_m = old_p + 1;
    e.frame = (p_m >= 0) && ((p_m % FRAME) == FRAME - 1);
    if (rst) begin
      pend_m = 16'h0; shad_m = 16'h0; pdp_m = 4'h0; sdp_m = 4'h0;
    end else if (old_p < 0 && load) begin
      pend_m = value; shad_m = value; pdp_m = dp; sdp_m = dp;
    end else if (old_p >= 0 && (old_p % FRAME) == FRAME - 1) begin
      if (load) begin pend_m = value; pdp_m = dp; end
      shad_m = pend_m; sdp_m = pdp_m;
    end else if (load) begin
      pend_m = value; pdp_m = dp;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare every presented output cycle against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (o_anode !== e.anode) begin
        errors++;
        $display("FAIL anode t=%0t got=%b exp=%b", $time, o_anode, e.anode);
      end
      checks++;
      if (o_leds !== e.leds) begin
        errors++;
        $display("FAIL leds t=%0t got=%b exp=%b", $time, o_leds, e.leds);
      end
      checks++;
      if (o_frame !== e.frame) begin
        errors++;
        $display("FAIL frame t=%0t got=%b exp=%b", $time, o_frame, e.frame);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * FRAME && !(p_m >= 0 && (p_m % FRAME) == ph); i++) step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0; dp = 4'h0; lz = 1'b0;
    repeat (3) step();
    // Enable and load 1234 while dark
    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h1234;
    step();
    repeat (70) step();
    // Mid-frame load: takes effect after the next frame boundary
    wait_phase(10); load = 1'b1; value = 16'hABCD; step();
    repeat (40) step();
    // Repeated loads, last one wins
    wait_phase(5); load = 1'b1; value = 16'h1111; step();
    load = 1'b1; value = 16'h2222; dp = 4'b0110; step();
    repeat (40) step();
    // Load coincident with the frame cycle bypasses the pending register
    wait_phase(FRAME - 1); load = 1'b1; value = 16'h5A3C; dp = 4'b1001; step();
    repeat (40) step();
    // Leading-zero suppression
    lz = 1'b1;
    load = 1'b1; value = 16'h0050; dp = 4'b0001; step();
    repeat (75) step();
    load = 1'b1; value = 16'h0000; dp = 4'b0000; step();
    repeat (75) step();
    lz = 1'b0;
    // Enable drop during digit 2 lit window, then re-enable
    wait_phase(2 * TD + 4); en = 1'b0; step();
    repeat (3) step();
    en = 1'b1;
    repeat (40) step();
    // Reset mid-SHOW with a coincident load
    wait_phase(TD + 5); rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp = 4'hF; step();
    rst = 1'b0;
    repeat (45) step();
    // Randomized traffic
    for (int it = 0; it < 50; it++) begin
      int r;
      r = $urandom_range(0, 9);
      value = 16'($urandom);
      dp = 4'($urandom);
      lz = 1'($urandom);
      if (r == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 4)) step();
        en = 1'b1;
      end else if (r == 1) begin
        rst = 1'b1; load = 1'($urandom); step(); rst = 1'b0;
      end else begin
        load = 1'b1; step();
      end
      repeat ($urandom_range(1, 25)) step();
    end
    en = 1'b0;
    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
